// File: rtl/sync_debounce.sv
// Multi-channel input conditioner: N-flop synchroniser, consecutive-sample
// debounce filter with optional prescale tick, and registered rise/fall pulses.
module sync_debounce #(
  parameter int               WIDTH           = 4,
  parameter int               STAGES          = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL       = {WIDTH{1'b0}}
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Tick,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  logic [WIDTH-1:0] r_sync [STAGES];
  logic [CNT_W-1:0] r_cnt  [WIDTH];
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  logic [WIDTH-1:0] w_s;
  logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_rise_nxt;
  logic [WIDTH-1:0] w_fall_nxt;

  // Synchroniser chain: stage 0 captures the raw pins, last stage feeds the filter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_sync[k] <= RESET_VAL;
      end
    end else begin
      r_sync[0] <= d;
      for (int k = 1; k < STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign w_s = r_sync[STAGES-1];

  // Filter next-state: any agreement clears the streak, Tick gates counting.
  always_comb begin
    w_q_nxt    = r_q;
    w_rise_nxt = {WIDTH{1'b0}};
    w_fall_nxt = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (w_s[i] == r_q[i]) begin
        w_cnt_nxt[i] = CNT_ZERO;
      end else if (!Tick) begin
        w_cnt_nxt[i] = r_cnt[i];
      end else if (r_cnt[i] == CNT_LAST) begin
        w_cnt_nxt[i]  = CNT_ZERO;
        w_q_nxt[i]    = w_s[i];
        w_rise_nxt[i] = w_s[i];
        w_fall_nxt[i] = ~w_s[i];
      end else begin
        w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
      end
    end
  end

  // Filter state and registered outputs; pulses line up with the new level.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= CNT_ZERO;
      end
      r_q    <= RESET_VAL;
      r_rise <= {WIDTH{1'b0}};
      r_fall <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_nxt[i];
      end
      r_q    <= w_q_nxt;
      r_rise <= w_rise_nxt;
      r_fall <= w_fall_nxt;
    end
  end

  assign q    = r_q;
  assign rise = r_rise;
  assign fall = r_fall;

endmodule

// File: tb/tb_sync_debounce.sv
// Self-checking bench for sync_debounce: cycle-by-cycle reference model plus
// directed scenarios with hand-computed expectations.
module tb_sync_debounce;

  localparam int ST = 2;
  localparam int DB = 4;

  logic       Clk;
  logic       Reset_n;
  logic       Tick;
  logic [3:0] d;
  logic [3:0] q, rise, fall;
  logic [3:0] d2;
  logic [3:0] q2, rise2, fall2;

  int checks   = 0;
  int failures = 0;
  bit started  = 0;
  bit pre_mode = 0;
  int pcnt     = 0;

  sync_debounce #(.WIDTH(4), .STAGES(ST), .DEBOUNCE_CYCLES(DB), .RESET_VAL(4'b0000)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .Tick(Tick), .d(d), .q(q), .rise(rise), .fall(fall)
  );

  sync_debounce #(.WIDTH(4), .STAGES(ST), .DEBOUNCE_CYCLES(DB), .RESET_VAL(4'b0101)) u_rv (
    .Clk(Clk), .Reset_n(Reset_n), .Tick(Tick), .d(d2), .q(q2), .rise(rise2), .fall(fall2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: s is the input sampled ST edges ago; q follows once
  // DB Tick-qualified samples in an unbroken disagreement streak are seen.
  logic [3:0] dq[$];
  logic [3:0] mq, mrise, mfall, s_m;
  int         streak [4];

  initial begin
    forever begin
      @(posedge Clk or negedge Reset_n);
      if (!Reset_n) begin
        dq.delete();
        for (int k = 0; k < ST; k++) dq.push_back(4'b0000);
        mq    = 4'b0000;
        mrise = 4'b0000;
        mfall = 4'b0000;
        for (int i = 0; i < 4; i++) streak[i] = 0;
      end else begin
        s_m = dq.pop_front();
        dq.push_back(d);
        mrise = 4'b0000;
        mfall = 4'b0000;
        for (int i = 0; i < 4; i++) begin
          if (s_m[i] == mq[i]) begin
            streak[i] = 0;
          end else if (Tick) begin
            streak[i] = streak[i] + 1;
            if (streak[i] >= DB) begin
              mq[i]     = s_m[i];
              mrise[i]  = s_m[i];
              mfall[i]  = ~s_m[i];
              streak[i] = 0;
            end
          end
        end
      end
    end
  end

  // Per-cycle compare against the model and the fixed-reset-value instance.
  initial begin
    forever begin
      @(negedge Clk);
      if (started) begin
        check("model_q", q, mq);
        check("model_rise", rise, mrise);
        check("model_fall", fall, mfall);
        check("rise_fall_overlap", rise & fall, 4'b0000);
        check("rv_q", q2, 4'b0101);
        check("rv_pulses", rise2 | fall2, 4'b0000);
      end
    end
  end

  task automatic cyc(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge Clk);
      #1;
      if (pre_mode) begin
        pcnt = pcnt + 1;
        Tick = ((pcnt % 4) == 0) ? 1'b1 : 1'b0;
      end else begin
        Tick = 1'b1;
      end
    end
  endtask

  initial begin
    Reset_n = 1'b0;
    Tick    = 1'b1;
    d       = 4'b0000;
    d2      = 4'b0101;
    cyc(3);
    started = 1;
    Reset_n = 1'b1;
    cyc(20);
    check("rst_q", q, 4'b0000);
    check("rst_pulses", rise | fall, 4'b0000);
    check("rst_rv_q", q2, 4'b0101);

    // Clean rise then fall on channel 0.
    d = 4'b0001;
    cyc(5);
    check("clean_q_e4", q, 4'b0000);
    cyc(1);
    check("clean_q_e5", q, 4'b0001);
    check("clean_rise_e5", rise, 4'b0001);
    cyc(1);
    check("clean_rise_e6", rise, 4'b0000);
    d = 4'b0000;
    cyc(6);
    check("clean_fall_e5", fall, 4'b0001);
    check("clean_fall_q", q, 4'b0000);
    cyc(6);

    // Glitch of 3 samples rejected; 4 samples accepted, then a fall.
    d = 4'b0010;
    cyc(3);
    d = 4'b0000;
    cyc(10);
    check("glitch3_q", q, 4'b0000);
    d = 4'b0010;
    cyc(4);
    d = 4'b0000;
    cyc(2);
    check("glitch4_q", q, 4'b0010);
    check("glitch4_rise", rise, 4'b0010);
    cyc(3);
    check("glitch4_q_e8", q, 4'b0010);
    cyc(1);
    check("glitch4_fall_e9", fall, 4'b0010);
    cyc(6);

    // Prescaled Tick, one cycle in four.
    pre_mode = 1;
    pcnt = 0;
    Tick = 1'b1;
    d = 4'b0100;
    cyc(16);
    check("pre_q_e15", q, 4'b0000);
    cyc(1);
    check("pre_q_e16", q, 4'b0100);
    check("pre_rise_e16", rise, 4'b0100);
    d = 4'b0000;
    cyc(24);
    check("pre_fall_done", q, 4'b0000);
    pcnt = 0;
    Tick = 1'b1;
    d = 4'b0100;
    cyc(9);
    d = 4'b0000;
    cyc(30);
    check("pre_cleared_q", q, 4'b0000);
    pre_mode = 0;
    Tick = 1'b1;
    cyc(4);

    // All channels at once.
    d = 4'b1111;
    cyc(6);
    check("all_rise", rise, 4'b1111);
    check("all_q", q, 4'b1111);
    cyc(1);
    check("all_rise_end", rise, 4'b0000);
    d = 4'b0000;
    cyc(6);
    check("all_fall", fall, 4'b1111);
    cyc(4);

    // Channel 3 bouncing every cycle while channel 0 rises cleanly.
    d = 4'b0001;
    for (int k = 0; k < 20; k++) begin
      d[3] = ~d[3];
      cyc(1);
    end
    cyc(6);
    check("bounce_q", q, 4'b0001);
    d = 4'b0000;
    cyc(8);
    check("bounce_settle", q, 4'b0000);

    // Reset asserted with channel 0 mid-count.
    d = 4'b0001;
    cyc(4);
    Reset_n = 1'b0;
    cyc(2);
    check("midrst_q", q, 4'b0000);
    check("midrst_pulses", rise | fall, 4'b0000);
    Reset_n = 1'b1;
    cyc(5);
    check("midrst_q_e4", q, 4'b0000);
    cyc(1);
    check("midrst_q_e5", q, 4'b0001);
    check("midrst_rise_e5", rise, 4'b0001);
    cyc(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_debounce.md
Name: sync_debounce

Overview:
- Parametrised multi-channel input conditioner for switches, buttons and other asynchronous inputs.
- Per channel: an N-flop synchroniser chain, a consecutive-sample debounce filter with an optional prescale tick, and registered rise/fall edge pulses.
- Sits directly behind the FPGA pins. Its outputs feed control FSMs, which then need no extra synchronisation or edge detection.

Parameters:
- WIDTH, 4, number of independent channels.
- STAGES, 2, synchroniser flops per channel; legal range 2..4.
- DEBOUNCE_CYCLES, 4, qualifying samples a changed input must hold before the output follows; legal range >=1, where 1 means no filtering.
- RESET_VAL, {WIDTH{1'b0}}, per-bit reset value for the chain and the debounced output.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, never overridden.

Ports:
- Clk  input  1  system clock.
- Reset_n  input  1  asynchronous active-low reset. Asserts asynchronously; release is treated as synchronous to Clk.
- Tick  input  1  debounce sample enable (prescaler strobe). Tie to 1'b1 to sample every cycle.
- d  input  WIDTH  raw asynchronous inputs.
- q  output  WIDTH  synchronised, debounced levels; registered.
- rise  output  WIDTH  one-cycle pulse per channel when q goes 0->1; registered.
- fall  output  WIDTH  one-cycle pulse per channel when q goes 1->0; registered.

Behaviour:
- Reset (Reset_n low, asynchronous):
  - every chain flop = RESET_VAL[i];
  - q = RESET_VAL;
  - all counters = 0;
  - rise = fall = 0.
  - Release produces no edge pulse.
- Chain: s[i] = last stage of channel i, and s[i] changes STAGES edges after d[i] is captured. Edge 0 is the first edge sampling the new d.
- Per-channel filter, evaluated every Clk edge:
  - s[i]==q[i]: cnt[i] <= 0. No output change.
  - s[i]!=q[i], Tick=0: cnt[i] holds.
  - s[i]!=q[i], Tick=1, cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - s[i]!=q[i], Tick=1, cnt[i] == DEBOUNCE_CYCLES-1: q[i] <= s[i], cnt[i] <= 0. Assert rise[i] if s[i]=1, else fall[i], for exactly one cycle, aligned with the new q.
- Any cycle with s[i]==q[i] clears a partial count, including a cycle where Tick=0. A glitch shorter than DEBOUNCE_CYCLES qualifying samples never reaches q.
- Latency with Tick=1: q[i] updates on edge STAGES-1+DEBOUNCE_CYCLES. With defaults that is edge 5, i.e. q is visible from the 6th cycle.
- rise and fall are never both 1 on the same channel. They deassert on the next edge unless a new transition qualifies, which is impossible before DEBOUNCE_CYCLES further samples.
- Channels are fully independent; simultaneous transitions on several channels each pulse in their own qualifying cycle.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap.
- Reset asserted mid-count: counter cleared, q forced to RESET_VAL, pulses dropped; no pulse on release.
- No combinational path from d or Tick to any output.

Test Plan:
- Reset/release: WIDTH=4, RESET_VAL=4'b0101, d=4'b0101 at release -> q=4'b0101 throughout, rise=fall=0 for 20 cycles.
- Clean edge, defaults, Tick=1: d[0] 0->1 before edge 0 -> q[0]=1 and rise[0]=1 after edge 5, rise[0]=0 after edge 6. A 1->0 change gives fall[0] with the same timing.
- Glitch rejection: d[1] high for 3 cycles then low -> q[1] stays 0, no rise. High for 4 cycles -> q[1]=1 with a single rise pulse. The subsequent low for 4+ cycles -> fall pulse.
- Tick prescale: Tick high one cycle in 4, d[2] rises and stays -> q[2] rises on the edge sampling the 4th Tick after s[2] changes. Repeat with d[2] dropping between Ticks 2 and 3 -> count cleared, no pulse.
- Simultaneous/independent: d=4'b1111 from 0 at once -> all rise bits pulse in the same cycle. d[3] bouncing every cycle while d[0] is stable -> only channel 0 pulses.
- Reset mid-count: assert Reset_n low when cnt[0]=2 with d[0]=1, release with d[0]=1 -> q[0]=0 after release, rise[0] on edge STAGES-1+4 measured from the first post-release edge.
